mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Execute-stage multiply/divide unit with architectural HI/LO registers.
- Consumes the two register-file read operands, after forwarding, for mult/multu/div/divu/mthi/mtlo.
- Models fixed multi-cycle latency through a busy counter.
- The hazard unit stalls D/E while `busy` is high, or while `start` is high with a mult/div op.
- mfhi/mflo read the `hi`/`lo` outputs directly, combinationally.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (and madd/maddu); legal range 1-31.
- DIV_CYCLES, 10, busy duration in cycles for div/divu; legal range 1-31.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  reset, synchronous, active-high.
- start  input  1  E-stage instruction is an MDU op; qualifies `op`.
- op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6=madd, 7=maddu.
- src_a  input  32  rs operand (dividend / multiplicand / mthi/mtlo data).
- src_b  input  32  rt operand (divisor / multiplier).
- busy  output  1  an operation is in flight; registered.
- done  output  1  one-cycle pulse in the cycle after the result is written; registered.
- hi  output  32  HI register; registered.
- lo  output  32  LO register; registered.

Behaviour:
- Reset: busy=0, done=0, hi=0, lo=0, counter=0, operand latches=0. Reset takes priority over every other event, including mid-operation; any in-flight result is discarded.
- Accept condition: start=1 and busy=0 at a rising edge. When start=1 and busy=1, `start` is ignored; upstream must hold the instruction, and the unit does not queue it.
- Accepting mult/multu/div/divu (and madd/maddu when enabled):
  - Latch src_a, src_b and op.
  - Load counter with the cycle count for the op; set busy=1.
  - hi/lo are unchanged at the accept edge.
- Countdown: on each edge with busy=1, counter decrements.
  - On the edge where counter==1: write hi/lo from the latched operands, busy<=0, done<=1.
  - busy is therefore high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES). New hi/lo are visible in the same cycle busy falls.
- done: high for exactly one cycle, then 0, unless another completion occurs.
- mthi/mtlo:
  - Accepted only when busy=0.
  - hi (or lo) <= src_a at the accept edge; the other register is unchanged.
  - No busy, no done.
- Arithmetic:
  - mult: {hi,lo} = signed 32x32 -> 64.
  - multu: {hi,lo} = unsigned 32x32 -> 64.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000; no trap.
  - Divisor 0 (div or divu): hi/lo are left unchanged at completion, but busy and done still run the full DIV_CYCLES.
- Operand capture: operands are sampled only at the accept edge. Changes on src_a/src_b while busy have no effect.
- Back-to-back: a new start may be accepted in the cycle busy falls, i.e. the cycle after the completion edge.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - op 6 (madd) does {hi,lo} <= {hi,lo} + signed product.
  - op 7 (maddu) does {hi,lo} <= {hi,lo} + unsigned product.
  - Both use MULT_CYCLES.
  - The accumulate uses the hi/lo values present at the completion edge; the sum wraps modulo 2^64.
- Not defined: ops 6/7 are treated as no-ops; no busy, no done, hi/lo unchanged.

Test Plan:
- mult, src_a=0xFFFFFFFE, src_b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once. Same operands with multu -> hi=0x00000002, lo=0xFFFFFFFA.
- div, src_a=0xFFFFFFF9 (-7), src_b=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/2 -> lo=3, hi=1. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi 0x12345678, then mtlo 0x9ABCDEF0 -> hi/lo update at each accept edge, busy stays 0. Then divu with src_b=0 -> busy 10 cycles, hi/lo remain 0x12345678/0x9ABCDEF0.
- Start multu 5x6, then drive start with mtlo 0xDEAD and change operands on cycle 2 of busy -> mtlo ignored, final hi=0, lo=30.
- Start div 100/7, assert reset on cycle 4 of busy -> next cycle busy=0, done=0, hi=lo=0, and no completion write afterwards.
- MDU_MADD_EN defined: mthi 0, mtlo 0xFFFFFFFF, then maddu 1x1 -> hi=1, lo=0. With the macro undefined, the same sequence -> no busy, hi=0, lo=0xFFFFFFFF.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - issue/result bundle between the E stage and the multiply/divide unit
//
// Signals (master = E stage / hazard logic, slave = mult_div_unit):
//   start  : E-stage instruction is an MDU op, qualifies op
//   op     : 0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo 6=madd 7=maddu
//   src_a  : rs operand (dividend / multiplicand / mthi-mtlo data)
//   src_b  : rt operand (divisor / multiplier)
//   busy   : an operation is in flight
//   done   : one-cycle pulse in the cycle after the result write
//   hi, lo : architectural HI/LO registers
interface mult_div_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, src_a, src_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - execute-stage multiply/divide unit with HI/LO registers and busy countdown
//
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high reset
//   bus    : mult_div_unit_if.slave (start/op/src_a/src_b in, busy/done/hi/lo out)
// Parameters:
//   MULT_CYCLES : busy length for mult/multu/madd/maddu (1-31)
//   DIV_CYCLES  : busy length for div/divu (1-31)
// Optional build macro:
//   MDU_MADD_EN : enables madd (op 6) and maddu (op 7); otherwise they are no-ops
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    mult_div_unit_if.slave        bus
);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MADDU = 3'd7
    } op_e;

    logic        r_busy;
    logic        r_done;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_a;
    logic [31:0] r_b;
    op_e         r_op;

    op_e         w_op_in;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_div_signed;
    logic [31:0] w_div_n;
    logic [31:0] w_div_d;
    logic [31:0] w_div_d_safe;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic        w_res_we;
    logic [63:0] w_res;

    assign w_op_in = op_e'(bus.op);

    // Low 64 bits of a 64x64 product of sign-extended operands equal the
    // signed 32x32 product, so one unsigned multiplier shape serves both.
    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Signed division runs on magnitudes and fixes signs afterwards. The
    // 0x80000000 / -1 case falls out naturally: magnitude 0x80000000 negated
    // stays 0x80000000 and the remainder is 0.
    assign w_div_signed = (r_op == OP_DIV);
    assign w_div_n      = (w_div_signed && r_a[31]) ? (~r_a + 32'd1) : r_a;
    assign w_div_d      = (w_div_signed && r_b[31]) ? (~r_b + 32'd1) : r_b;
    // A zero divisor never writes; substitute 1 only to keep the divider defined.
    assign w_div_d_safe = (w_div_d == 32'd0) ? 32'd1 : w_div_d;
    assign w_uq         = w_div_n / w_div_d_safe;
    assign w_ur         = w_div_n % w_div_d_safe;
    assign w_q = (w_div_signed && (r_a[31] ^ r_b[31])) ? (~w_uq + 32'd1) : w_uq;
    assign w_r = (w_div_signed && r_a[31])             ? (~w_ur + 32'd1) : w_ur;

    always_comb begin
        w_res_we = 1'b0;
        w_res    = {r_hi, r_lo};
        case (r_op)
            OP_MULT:  begin w_res_we = 1'b1; w_res = w_prod_s; end
            OP_MULTU: begin w_res_we = 1'b1; w_res = w_prod_u; end
            OP_DIV, OP_DIVU: begin
                w_res_we = (r_b != 32'd0);
                w_res    = {w_r, w_q};
            end
`ifdef MDU_MADD_EN
            // Accumulates onto HI/LO as they stand at the completion edge.
            OP_MADD:  begin w_res_we = 1'b1; w_res = {r_hi, r_lo} + w_prod_s; end
            OP_MADDU: begin w_res_we = 1'b1; w_res = {r_hi, r_lo} + w_prod_u; end
`endif
            default:  begin w_res_we = 1'b0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= 5'd0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_a    <= 32'd0;
            r_b    <= 32'd0;
            r_op   <= OP_MULT;
        end else begin
            r_done <= 1'b0;
            if (r_busy) begin
                // start is ignored while busy; upstream holds the instruction.
                if (r_cnt == 5'd1) begin
                    if (w_res_we) begin
                        r_hi <= w_res[63:32];
                        r_lo <= w_res[31:0];
                    end
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_cnt  <= 5'd0;
                end else begin
                    r_cnt <= r_cnt - 5'd1;
                end
            end else if (bus.start) begin
                case (w_op_in)
                    OP_MULT, OP_MULTU: begin
                        r_a    <= bus.src_a;
                        r_b    <= bus.src_b;
                        r_op   <= w_op_in;
                        r_cnt  <= 5'(MULT_CYCLES);
                        r_busy <= 1'b1;
                    end
                    OP_DIV, OP_DIVU: begin
                        r_a    <= bus.src_a;
                        r_b    <= bus.src_b;
                        r_op   <= w_op_in;
                        r_cnt  <= 5'(DIV_CYCLES);
                        r_busy <= 1'b1;
                    end
                    OP_MTHI: r_hi <= bus.src_a;
                    OP_MTLO: r_lo <= bus.src_a;
`ifdef MDU_MADD_EN
                    OP_MADD, OP_MADDU: begin
                        r_a    <= bus.src_a;
                        r_b    <= bus.src_b;
                        r_op   <= w_op_in;
                        r_cnt  <= 5'(MULT_CYCLES);
                        r_busy <= 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
